// File: rtl/cheri_rvfi_dii_injector.sv
// Replays the RVFI-DII instruction stream into the core frontend, keeping every
// injected instruction until it commits so a flush can re-fetch it, and holds
// the core in reset between traces when an end-of-trace command reaches the head.
module cheri_rvfi_dii_injector #(
   parameter int unsigned DepthLog2   = 3,
   parameter int unsigned ResetCycles = 4,
   parameter int unsigned SeqWidth    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dii_valid_i,
   output logic                dii_ready_o,
   input  logic                dii_cmd_i,
   input  logic [31:0]         dii_insn_i,
   output logic                fetch_valid_o,
   input  logic                fetch_ready_i,
   output logic [31:0]         fetch_insn_o,
   output logic [SeqWidth-1:0] fetch_seq_o,
   input  logic                commit_i,
   input  logic                flush_i,
   output logic                trace_done_o,
   output logic                core_rst_req_o,
   output logic                err_o
);

   localparam int unsigned Depth = 1 << DepthLog2;
   localparam int unsigned PtrW  = DepthLog2 + 1;
   localparam int unsigned CntW  = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(ResetCycles - 1);

   localparam logic [0:0] StRun = 1'b0;
   localparam logic [0:0] StRst = 1'b1;

   // Handshakes (host and fetch side): a transfer happens in exactly the cycle
   // where valid and ready are both high; valid never depends on ready.
   logic [PtrW-1:0]     wr_q, wr_d, fe_q, fe_d, cm_q, cm_d;
   logic [SeqWidth-1:0] fseq_q, fseq_d, cseq_q, cseq_d;
   logic [0:0]          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                eot_pend_q, eot_pend_d;
   logic                err_q, err_d;

   logic                buf_cmd_q  [Depth];
   logic [31:0]         buf_insn_q [Depth];

   logic [DepthLog2-1:0] wr_idx, fe_idx, cm_idx;
   logic                 run, full, wr_en, fetch_hs, eot_head, commit_ok;
   logic [PtrW-1:0]      cm_next;
   logic [SeqWidth-1:0]  cseq_next;

   assign wr_idx = wr_q[DepthLog2-1:0];
   assign fe_idx = fe_q[DepthLog2-1:0];
   assign cm_idx = cm_q[DepthLog2-1:0];

   always_comb begin
      run  = (state_q == StRun);
      full = (wr_q[DepthLog2] != cm_q[DepthLog2]) && (wr_idx == cm_idx);

      dii_ready_o    = !full && run && !eot_pend_q;
      wr_en          = dii_valid_i && dii_ready_o;
      // An EOT entry is never offered, so fetch stalls on it until it commits out.
      fetch_valid_o  = run && (fe_q != wr_q) && buf_cmd_q[fe_idx] && !flush_i;
      fetch_insn_o   = buf_insn_q[fe_idx];
      fetch_seq_o    = fseq_q;
      fetch_hs       = fetch_valid_o && fetch_ready_i;
      eot_head       = run && (cm_q != wr_q) && !buf_cmd_q[cm_idx];
      trace_done_o   = eot_head;
      core_rst_req_o = !run;
      err_o          = err_q;

      commit_ok = run && !eot_head && commit_i && (cm_q != fe_q);
      cm_next   = cm_q + PtrW'(commit_ok);
      cseq_next = cseq_q + SeqWidth'(commit_ok);
   end

   always_comb begin
      wr_d       = wr_q;
      fe_d       = fe_q;
      cm_d       = cm_q;
      fseq_d     = fseq_q;
      cseq_d     = cseq_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      eot_pend_d = eot_pend_q;
      err_d      = err_q | (commit_i && !commit_ok);

      if (wr_en) begin
         wr_d = wr_q + PtrW'(1);
         if (!dii_cmd_i) begin
            eot_pend_d = 1'b1;
         end
      end

      if (state_q == StRun) begin
         if (eot_head) begin
            cm_d    = cm_q + PtrW'(1);
            fe_d    = cm_q + PtrW'(1);
            state_d = StRst;
            cnt_d   = CntLoad;
         end else begin
            cm_d   = cm_next;
            cseq_d = cseq_next;
            if (flush_i) begin
               fe_d   = cm_next;
               fseq_d = cseq_next;
            end else if (fetch_hs) begin
               fe_d   = fe_q + PtrW'(1);
               fseq_d = fseq_q + SeqWidth'(1);
            end
         end
      end else begin
         if (cnt_q == '0) begin
            state_d    = StRun;
            fseq_d     = '0;
            cseq_d     = '0;
            eot_pend_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q       <= '0;
         fe_q       <= '0;
         cm_q       <= '0;
         fseq_q     <= '0;
         cseq_q     <= '0;
         state_q    <= StRun;
         cnt_q      <= '0;
         eot_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         fe_q       <= fe_d;
         cm_q       <= cm_d;
         fseq_q     <= fseq_d;
         cseq_q     <= cseq_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         eot_pend_q <= eot_pend_d;
         err_q      <= err_d;
      end
   end

   // Storage needs no reset: only slots between cm and wr are ever read.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         buf_cmd_q[wr_idx]  <= dii_cmd_i;
         buf_insn_q[wr_idx] <= dii_insn_i;
      end
   end

endmodule

// File: tb/tb_cheri_rvfi_dii_injector.sv
// Bench for cheri_rvfi_dii_injector: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the instruction stream.
module tb_cheri_rvfi_dii_injector;

   localparam int RESET_CYCLES = 4;
   localparam int DEPTH        = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        dii_valid_i = 1'b0;
   logic        dii_ready_o;
   logic        dii_cmd_i = 1'b1;
   logic [31:0] dii_insn_i = '0;
   logic        fetch_valid_o;
   logic        fetch_ready_i = 1'b0;
   logic [31:0] fetch_insn_o;
   logic [15:0] fetch_seq_o;
   logic        commit_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        trace_done_o;
   logic        core_rst_req_o;
   logic        err_o;

   cheri_rvfi_dii_injector #(
      .DepthLog2  (3),
      .ResetCycles(RESET_CYCLES),
      .SeqWidth   (16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .dii_valid_i   (dii_valid_i),
      .dii_ready_o   (dii_ready_o),
      .dii_cmd_i     (dii_cmd_i),
      .dii_insn_i    (dii_insn_i),
      .fetch_valid_o (fetch_valid_o),
      .fetch_ready_i (fetch_ready_i),
      .fetch_insn_o  (fetch_insn_o),
      .fetch_seq_o   (fetch_seq_o),
      .commit_i      (commit_i),
      .flush_i       (flush_i),
      .trace_done_o  (trace_done_o),
      .core_rst_req_o(core_rst_req_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: the uncommitted stream as a queue; the first m_nf entries have been fetched.
   bit          m_cmd[$];
   logic [31:0] m_insn[$];
   int          m_nf;
   logic [15:0] m_fseq, m_cseq;
   bit          m_in_rst;
   int          m_rst_left;
   bit          m_eot_pend;
   bit          m_err;
   bit          e_ready, e_fvalid, e_done;

   task automatic model_reset();
      m_cmd.delete();
      m_insn.delete();
      m_nf = 0; m_fseq = '0; m_cseq = '0;
      m_in_rst = 0; m_rst_left = 0; m_eot_pend = 0; m_err = 0;
   endtask

   task automatic model_outputs();
      e_done   = !m_in_rst && m_cmd.size() > 0 && m_cmd[0] == 0;
      e_ready  = m_cmd.size() < DEPTH && !m_in_rst && !m_eot_pend;
      e_fvalid = !m_in_rst && !flush_i && m_nf < m_cmd.size() && m_cmd[m_nf] == 1;
   endtask

   task automatic check_outputs();
      model_outputs();
      chk("dii_ready", 32'(dii_ready_o), 32'(e_ready));
      chk("fetch_valid", 32'(fetch_valid_o), 32'(e_fvalid));
      if (e_fvalid) chk("fetch_insn", fetch_insn_o, m_insn[m_nf]);
      chk("fetch_seq", 32'(fetch_seq_o), 32'(m_fseq));
      chk("trace_done", 32'(trace_done_o), 32'(e_done));
      chk("core_rst_req", 32'(core_rst_req_o), 32'(m_in_rst));
      chk("err", 32'(err_o), 32'(m_err));
   endtask

   task automatic model_update();
      bit wr, did_commit;
      wr = dii_valid_i && e_ready;
      if (m_in_rst) begin
         if (commit_i) m_err = 1;
         if (m_rst_left == 0) begin
            m_in_rst = 0; m_fseq = '0; m_cseq = '0; m_eot_pend = 0;
         end else begin
            m_rst_left--;
         end
      end else if (e_done) begin
         if (commit_i) m_err = 1;
         void'(m_cmd.pop_front());
         void'(m_insn.pop_front());
         m_in_rst = 1;
         m_rst_left = RESET_CYCLES - 1;
      end else begin
         did_commit = commit_i && m_nf > 0;
         if (commit_i && !did_commit) m_err = 1;
         if (did_commit) begin
            void'(m_cmd.pop_front());
            void'(m_insn.pop_front());
            m_nf--;
            m_cseq++;
         end
         if (flush_i) begin
            m_nf = 0;
            m_fseq = m_cseq;
         end else if (e_fvalid && fetch_ready_i) begin
            m_nf++;
            m_fseq++;
         end
      end
      if (wr) begin
         m_cmd.push_back(dii_cmd_i);
         m_insn.push_back(dii_insn_i);
         if (!dii_cmd_i) m_eot_pend = 1;
      end
   endtask

   // Called at posedge+1: drive, check mid-cycle, advance model at the edge.
   task automatic step(input logic v, input logic c, input logic [31:0] ins,
                       input logic fr, input logic cm, input logic fl);
      dii_valid_i = v; dii_cmd_i = c; dii_insn_i = ins;
      fetch_ready_i = fr; commit_i = cm; flush_i = fl;
      #2;
      check_outputs();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic idle(input logic fr);
      step(1'b0, 1'b1, 32'h0, fr, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      dii_valid_i = 0; fetch_ready_i = 0; commit_i = 0; flush_i = 0;
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   logic [31:0] vals[4];
   int n_done, n_rst;

   initial begin
      vals[0] = 32'h00000013; vals[1] = 32'h00100093;
      vals[2] = 32'h00200113; vals[3] = 32'h00300193;

      do_reset();
      #1;
      chk("rst_ready", 32'(dii_ready_o), 32'd1);
      chk("rst_fvalid", 32'(fetch_valid_o), 32'd0);
      chk("rst_done", 32'(trace_done_o), 32'd0);
      chk("rst_corerst", 32'(core_rst_req_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);

      // three writes streamed straight through to fetch
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, vals[i], 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);

      // fill all slots; freeing one by commit re-opens the host side
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
      #1 chk("full_ready", 32'(dii_ready_o), 32'd0);
      idle(1'b1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      #1 chk("unfull_ready", 32'(dii_ready_o), 32'd1);

      // fetch 4, commit 1, flush: replay from entry 1
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
      #1 chk("replay_insn", fetch_insn_o, vals[1]);
      chk("replay_seq", 32'(fetch_seq_o), 32'd1);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // flush coinciding with commit
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
      #1 chk("flushc_insn", fetch_insn_o, vals[1]);
      chk("flushc_seq", 32'(fetch_seq_o), 32'd1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // end of trace: one pulse, fixed-length core reset, counters cleared
      do_reset();
      step(1'b1, 1'b1, vals[0], 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, vals[1], 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      n_done = 0; n_rst = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_done += int'(trace_done_o);
         n_rst  += int'(core_rst_req_o);
         idle(1'b1);
      end
      chk("eot_pulses", 32'(n_done), 32'd1);
      chk("eot_rst_len", 32'(n_rst), 32'd4);
      #1 chk("eot_ready", 32'(dii_ready_o), 32'd1);
      chk("eot_seq", 32'(fetch_seq_o), 32'd0);

      // illegal commit is sticky; async reset mid-trace (during core reset) clears all
      do_reset();
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, vals[2], 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      #1 chk("pre_rst_corerst", 32'(core_rst_req_o), 32'd1);
      chk("pre_rst_err", 32'(err_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("arst_corerst", 32'(core_rst_req_o), 32'd0);
      chk("arst_err", 32'(err_o), 32'd0);
      chk("arst_ready", 32'(dii_ready_o), 32'd1);
      chk("arst_fvalid", 32'(fetch_valid_o), 32'd0);
      chk("arst_done", 32'(trace_done_o), 32'd0);
      do_reset();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic v, c, fr, cm, fl;
         v  = ($urandom_range(0, 2) != 0);
         c  = ($urandom_range(0, 19) != 0);
         fr = ($urandom_range(0, 3) != 0);
         cm = (m_nf > 0) && ($urandom_range(0, 2) == 0);
         if (i > 560 && $urandom_range(0, 9) == 0) cm = 1'b1;
         fl = ($urandom_range(0, 11) == 0);
         step(v, c, $urandom, fr, cm, fl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
